// File: rtl/timer_irq_pkg.sv
// Shared types and constants for the timer-interrupt BCD tick counter.
package timer_irq_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        INC    = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam logic [2:0] TIMER_STATUS_ADDR = 3'd0;

    // Segment patterns are stored active-high {g..a}; polarity is applied at the output.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Entries 10..15 are blank; the counter never produces them.
    localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/timer_irq_bcd_counter_if.sv
// Avalon-MM write-only master link from the tick counter to the interval timer.
interface timer_irq_bcd_counter_if;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [15:0] m_writedata;
    logic        m_waitrequest;

    modport master (
        output m_address, m_chipselect, m_write_n, m_writedata,
        input  m_waitrequest
    );

    modport slave (
        input  m_address, m_chipselect, m_write_n, m_writedata,
        output m_waitrequest
    );
endinterface

// File: rtl/timer_irq_bcd_counter_bcd_to_seg7.sv
// One BCD digit to active-high 7-segment pattern {g..a}.
module bcd_to_seg7
    import timer_irq_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);
    assign seg_c = SEG_LUT[bcd];
endmodule

// File: rtl/timer_irq_bcd_counter.sv
// Acknowledges timer timeouts over Avalon-MM and counts them on a BCD display.
// Optional decoder: TIMER_IRQ_BCD_HEX_DECODE_EN (undefined -> hex held blank).
module timer_irq_bcd_counter
    import timer_irq_pkg::*;
#(
    parameter int unsigned DIGITS         = 3,
    parameter logic [2:0]  STATUS_ADDR    = TIMER_STATUS_ADDR,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    timer_irq,
    input  logic                    run,
    input  logic                    clear,
    timer_irq_bcd_counter_if.master bus,
    output logic [4*DIGITS-1:0]     count_bcd,
    output logic                    tick_pulse,
    output logic                    wrap_pulse,
    output logic [7*DIGITS-1:0]     hex
);

    state_t               state_q;
    state_t               next_state_c;
    logic                 inc_en_c;
    logic                 carry_c;
    logic [4*DIGITS-1:0]  count_inc_c;
    logic                 cs_q;
    logic                 write_n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= next_state_c;
    end

    // Increment is taken on the ACK->INC edge so count lands 2 cycles after irq.
    always_comb begin
        next_state_c = state_q;
        inc_en_c     = 1'b0;
        case (state_q)
            IDLE:   if (timer_irq && run) next_state_c = ACK;
            ACK:    if (!bus.m_waitrequest) begin
                        next_state_c = INC;
                        inc_en_c     = run;
                    end
            INC:    next_state_c = SETTLE;
            SETTLE: next_state_c = IDLE;
            default: next_state_c = IDLE;
        endcase
    end

    // Bus strobes are registered from the next state: high only while in ACK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
        end else begin
            cs_q      <= (next_state_c == ACK);
            write_n_q <= (next_state_c != ACK);
        end
    end

    assign bus.m_chipselect = cs_q;
    assign bus.m_write_n    = write_n_q;
    assign bus.m_address    = STATUS_ADDR;
    assign bus.m_writedata  = 16'h0000;

    // Ripple decimal carry; carry out of the top digit means all digits were 9.
    always_comb begin
        carry_c     = 1'b1;
        count_inc_c = count_bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry_c) begin
                if (count_bcd[4*i +: 4] == 4'd9) begin
                    count_inc_c[4*i +: 4] = 4'd0;
                end else begin
                    count_inc_c[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                    carry_c               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_bcd  <= '0;
            tick_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            tick_pulse <= inc_en_c;
            wrap_pulse <= inc_en_c && carry_c && !clear;
            if (clear)         count_bcd <= '0;
            else if (inc_en_c) count_bcd <= count_inc_c;
        end
    end

`ifdef TIMER_IRQ_BCD_HEX_DECODE_EN
    localparam logic [SEG_W-1:0] SEG_ZERO = SEG_ACTIVE_LOW ? ~SEG_LUT[0] : SEG_LUT[0];

    logic [7*DIGITS-1:0] seg_c;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
        bcd_to_seg7 u_dec (
            .bcd   (count_bcd[4*g +: 4]),
            .seg_c (seg_c[7*g +: 7])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hex <= {DIGITS{SEG_ZERO}};
        else          hex <= SEG_ACTIVE_LOW ? ~seg_c : seg_c;
    end
`else
    localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    assign hex = {DIGITS{SEG_OFF}};
`endif

endmodule
